// File: rtl/exc_sequencer.sv
// Exception/interrupt entry and eret sequencer sitting beside CP0 in M; arbitration is combinational,
// redirect issues in the request cycle and flush holds FLUSH_CYCLES more cycles; new requests are ignored while busy.
module exc_sequencer #(
  parameter logic [31:0] HANDLER_PC   = 32'h0000_4180,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic [4:0]  exc_f,
  input  logic [4:0]  exc_d,
  input  logic [4:0]  exc_e,
  input  logic [4:0]  exc_m,
  input  logic        eret_m,
  input  logic [5:0]  dev_int,
  input  logic [5:0]  int_ack,
  input  logic        cp0_req,
  input  logic [31:0] cp0_epc,
  output logic [4:0]  cp0_exc_code,
  output logic [31:0] cp0_vpc,
  output logic        cp0_bd,
  output logic [5:0]  cp0_hw_int,
  output logic        cp0_exl_clr,
  output logic        flush,
  output logic [1:0]  npc_sel,
  output logic [31:0] npc_target,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_ENTER = 2'd1,
    ST_ERET  = 2'd2
  } state_e;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [5:0]  int_pend_q, int_pend_d;
  logic [4:0]  exc_arb;

  if (FLUSH_CYCLES == 0 || FLUSH_CYCLES > 7) begin : g_bad_flush_cycles
    always_ff @(posedge clk) begin
      assert (1'b0) else $error("exc_sequencer: FLUSH_CYCLES=%0d outside 1..7", FLUSH_CYCLES);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      cnt_q      <= 3'd0;
      int_pend_q <= 6'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      int_pend_q <= int_pend_d;
    end
  end

  // Oldest detection stage wins.
  always_comb begin
    exc_arb = 5'd0;
    if (exc_f != 5'd0)      exc_arb = exc_f;
    else if (exc_d != 5'd0) exc_arb = exc_d;
    else if (exc_e != 5'd0) exc_arb = exc_e;
    else                    exc_arb = exc_m;
  end

  assign cp0_vpc = pc_m;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    int_pend_d   = (int_pend_q | dev_int) & ~int_ack;
    cp0_exc_code = 5'd0;
    cp0_bd       = 1'b0;
    cp0_hw_int   = 6'd0;
    cp0_exl_clr  = 1'b0;
    flush        = 1'b0;
    npc_sel      = 2'b00;
    npc_target   = 32'd0;
    busy         = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (m_valid) begin
          cp0_exc_code = exc_arb;
          cp0_bd       = bd_m;
        end
        cp0_hw_int = int_pend_q;
        // A pending exception/interrupt takes precedence; a coincident eret is the victim.
        if (cp0_req) begin
          state_d    = ST_ENTER;
          cnt_d      = FLUSH_LOAD;
          flush      = 1'b1;
          npc_sel    = 2'b01;
          npc_target = HANDLER_PC;
        end else if (eret_m && m_valid) begin
          state_d     = ST_ERET;
          cnt_d       = FLUSH_LOAD;
          flush       = 1'b1;
          npc_sel     = 2'b10;
          npc_target  = cp0_epc;
          cp0_exl_clr = 1'b1;
        end
      end
      ST_ENTER, ST_ERET: begin
        flush = 1'b1;
        busy  = 1'b1;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = 3'd0;
      end
    endcase

    // Reset is asynchronous, so the combinational outputs are silenced with it too.
    if (reset) begin
      cp0_exc_code = 5'd0;
      cp0_bd       = 1'b0;
      cp0_hw_int   = 6'd0;
      cp0_exl_clr  = 1'b0;
      flush        = 1'b0;
      npc_sel      = 2'b00;
      npc_target   = 32'd0;
      busy         = 1'b0;
    end
  end

endmodule

// File: tb/tb_exc_sequencer.sv
// Bench for exc_sequencer: two instances (FLUSH_CYCLES 1 and 5) share all inputs.
module tb_exc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_valid;
  logic [31:0] pc_m;
  logic        bd_m;
  logic [4:0]  exc_f, exc_d, exc_e, exc_m;
  logic        eret_m;
  logic [5:0]  dev_int, int_ack;
  logic        cp0_req;
  logic [31:0] cp0_epc;

  logic [4:0]  exc_code_1, exc_code_5;
  logic [31:0] vpc_1, vpc_5;
  logic        bd_1, bd_5;
  logic [5:0]  hw_int_1, hw_int_5;
  logic        exl_clr_1, exl_clr_5;
  logic        flush_1, flush_5;
  logic [1:0]  sel_1, sel_5;
  logic [31:0] tgt_1, tgt_5;
  logic        busy_1, busy_5;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  exc_sequencer #(.HANDLER_PC(32'h0000_4180), .FLUSH_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .m_valid(m_valid), .pc_m(pc_m), .bd_m(bd_m),
    .exc_f(exc_f), .exc_d(exc_d), .exc_e(exc_e), .exc_m(exc_m), .eret_m(eret_m),
    .dev_int(dev_int), .int_ack(int_ack), .cp0_req(cp0_req), .cp0_epc(cp0_epc),
    .cp0_exc_code(exc_code_1), .cp0_vpc(vpc_1), .cp0_bd(bd_1), .cp0_hw_int(hw_int_1),
    .cp0_exl_clr(exl_clr_1), .flush(flush_1), .npc_sel(sel_1), .npc_target(tgt_1),
    .busy(busy_1)
  );

  exc_sequencer #(.HANDLER_PC(32'h0000_4180), .FLUSH_CYCLES(5)) u_dut5 (
    .clk(clk), .reset(reset), .m_valid(m_valid), .pc_m(pc_m), .bd_m(bd_m),
    .exc_f(exc_f), .exc_d(exc_d), .exc_e(exc_e), .exc_m(exc_m), .eret_m(eret_m),
    .dev_int(dev_int), .int_ack(int_ack), .cp0_req(cp0_req), .cp0_epc(cp0_epc),
    .cp0_exc_code(exc_code_5), .cp0_vpc(vpc_5), .cp0_bd(bd_5), .cp0_hw_int(hw_int_5),
    .cp0_exl_clr(exl_clr_5), .flush(flush_5), .npc_sel(sel_5), .npc_target(tgt_5),
    .busy(busy_5)
  );

  task automatic idle_inputs();
    m_valid = 1'b1; pc_m = 32'h0000_3000; bd_m = 1'b0;
    exc_f = 5'd0; exc_d = 5'd0; exc_e = 5'd0; exc_m = 5'd0;
    eret_m = 1'b0; dev_int = 6'd0; int_ack = 6'd0; cp0_req = 1'b0; cp0_epc = 32'd0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    idle_inputs();
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    m_valid = 1'b1; exc_e = 5'd12; bd_m = 1'b1; cp0_req = 1'b1; eret_m = 1'b1;
    dev_int = 6'h3f; pc_m = 32'h0000_1234; cp0_epc = 32'h0000_5555;
    @(negedge clk);
    total++;
    if ({exc_code_1, bd_1, hw_int_1, exl_clr_1, flush_1, sel_1, tgt_1, busy_1} !== 48'd0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0",
        {exc_code_1, bd_1, hw_int_1, exl_clr_1, flush_1, sel_1, tgt_1, busy_1});
    end
    total++;
    if (vpc_1 !== 32'h0000_1234) begin bad++; $display("FAIL reset_vpc: got %h want 00001234", vpc_1); end
    total++;
    if ({flush_5, busy_5, sel_5} !== 4'd0) begin
      bad++; $display("FAIL reset_dut5: got %b want 0000", {flush_5, busy_5, sel_5});
    end
    next_cycle();
    idle_inputs();
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({busy_1, flush_1, hw_int_1} !== 8'd0) begin
      bad++; $display("FAIL reset_release: got %b want 0", {busy_1, flush_1, hw_int_1});
    end
    next_cycle();
  endtask

  task automatic test_exc_entry();
    int fl5 = 0;
    int bz5 = 0;
    idle_inputs();
    exc_d = 5'd10; exc_e = 5'd12; pc_m = 32'h0000_3008; cp0_req = 1'b1;
    @(negedge clk);
    total++;
    if (exc_code_1 !== 5'd10) begin bad++; $display("FAIL entry_exc_code: got %0d want 10", exc_code_1); end
    total++;
    if (vpc_1 !== 32'h0000_3008) begin bad++; $display("FAIL entry_vpc: got %h want 00003008", vpc_1); end
    total++;
    if ({sel_1, tgt_1} !== {2'b01, 32'h0000_4180}) begin
      bad++; $display("FAIL entry_redirect: got sel=%b tgt=%h want 01/00004180", sel_1, tgt_1);
    end
    total++;
    if ({flush_1, busy_1} !== 2'b10) begin bad++; $display("FAIL entry_c0: got %b want 10", {flush_1, busy_1}); end
    fl5 += int'(flush_5); bz5 += int'(busy_5);
    for (int c = 1; c < 10; c++) begin
      next_cycle();
      idle_inputs();
      @(negedge clk);
      fl5 += int'(flush_5); bz5 += int'(busy_5);
      if (c == 1) begin
        total++;
        if ({flush_1, busy_1, sel_1} !== 4'b1100) begin
          bad++; $display("FAIL entry_c1: got %b want 1100", {flush_1, busy_1, sel_1});
        end
      end
      if (c == 2) begin
        total++;
        if ({flush_1, busy_1} !== 2'b00) begin bad++; $display("FAIL entry_c2: got %b want 00", {flush_1, busy_1}); end
      end
    end
    total++;
    if (fl5 != 6 || bz5 != 5) begin
      bad++; $display("FAIL entry_len5: got flush=%0d busy=%0d want 6/5", fl5, bz5);
    end
    next_cycle();
  endtask

  task automatic test_bubble();
    idle_inputs();
    m_valid = 1'b0; exc_m = 5'd4; bd_m = 1'b1; pc_m = 32'h0000_3010;
    @(negedge clk);
    total++;
    if ({exc_code_1, bd_1, flush_1} !== 7'd0) begin
      bad++; $display("FAIL bubble: got %b want 0", {exc_code_1, bd_1, flush_1});
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (busy_1 !== 1'b0) begin bad++; $display("FAIL bubble_busy: got %b want 0", busy_1); end
    next_cycle();
  endtask

  task automatic test_int_latch();
    idle_inputs();
    dev_int = 6'b000100;
    @(negedge clk);
    total++;
    if (hw_int_1 !== 6'd0) begin bad++; $display("FAIL int_pre: got %b want 000000", hw_int_1); end
    next_cycle();
    dev_int = 6'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (hw_int_1 !== 6'b000100) begin bad++; $display("FAIL int_hold%0d: got %b want 000100", i, hw_int_1); end
      next_cycle();
    end
    int_ack = 6'b000100;
    @(negedge clk);
    total++;
    if (hw_int_1 !== 6'b000100) begin bad++; $display("FAIL int_ackcyc: got %b want 000100", hw_int_1); end
    next_cycle();
    int_ack = 6'd0;
    @(negedge clk);
    total++;
    if (hw_int_1 !== 6'd0) begin bad++; $display("FAIL int_cleared: got %b want 000000", hw_int_1); end
    next_cycle();
    dev_int = 6'b100000; int_ack = 6'b100000;
    next_cycle();
    int_ack = 6'd0;
    @(negedge clk);
    total++;
    if (hw_int_1 !== 6'd0) begin bad++; $display("FAIL int_ackwins: got %b want 000000", hw_int_1); end
    next_cycle();
    dev_int = 6'd0;
    @(negedge clk);
    total++;
    if (hw_int_1 !== 6'b100000) begin bad++; $display("FAIL int_reset_after_ack: got %b want 100000", hw_int_1); end
    int_ack = 6'b100000;
    next_cycle();
    idle_cycles(1);
  endtask

  task automatic test_eret();
    idle_inputs();
    eret_m = 1'b1; cp0_epc = 32'h0000_3020;
    @(negedge clk);
    total++;
    if ({exl_clr_1, flush_1, sel_1, tgt_1} !== {1'b1, 1'b1, 2'b10, 32'h0000_3020}) begin
      bad++; $display("FAIL eret_c0: got exl=%b fl=%b sel=%b tgt=%h want 1/1/10/00003020",
        exl_clr_1, flush_1, sel_1, tgt_1);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    total++;
    if ({exl_clr_1, busy_1, flush_1, sel_1} !== 5'b01100) begin
      bad++; $display("FAIL eret_c1: got %b want 01100", {exl_clr_1, busy_1, flush_1, sel_1});
    end
    next_cycle();
    @(negedge clk);
    total++;
    if ({busy_1, flush_1} !== 2'b00) begin bad++; $display("FAIL eret_done: got %b want 00", {busy_1, flush_1}); end
    idle_cycles(8);
  endtask

  task automatic test_eret_vs_req();
    idle_inputs();
    eret_m = 1'b1; cp0_req = 1'b1; cp0_epc = 32'h0000_3020;
    @(negedge clk);
    total++;
    if ({exl_clr_1, sel_1, tgt_1} !== {1'b0, 2'b01, 32'h0000_4180}) begin
      bad++; $display("FAIL eret_vs_req: got exl=%b sel=%b tgt=%h want 0/01/00004180", exl_clr_1, sel_1, tgt_1);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    total++;
    if ({exl_clr_1, busy_1} !== 2'b01) begin
      bad++; $display("FAIL eret_vs_req_c1: got %b want 01", {exl_clr_1, busy_1});
    end
    idle_cycles(8);
  endtask

  task automatic test_reset_mid_enter();
    idle_inputs();
    cp0_req = 1'b1; dev_int = 6'b000001;
    next_cycle();
    idle_inputs();
    next_cycle();
    @(negedge clk);
    total++;
    if ({flush_5, busy_5} !== 2'b11) begin bad++; $display("FAIL mid_enter_busy: got %b want 11", {flush_5, busy_5}); end
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({flush_5, busy_5, sel_5} !== 4'd0) begin
      bad++; $display("FAIL mid_enter_reset: got %b want 0000", {flush_5, busy_5, sel_5});
    end
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({flush_5, busy_5, hw_int_5} !== 8'd0) begin
      bad++; $display("FAIL mid_enter_after: got %b want 0", {flush_5, busy_5, hw_int_5});
    end
    next_cycle();
    @(negedge clk);
    total++;
    if ({flush_5, busy_5} !== 2'b00) begin bad++; $display("FAIL mid_enter_stay: got %b want 00", {flush_5, busy_5}); end
    next_cycle();
  endtask

  task automatic test_random();
    int left [2];
    int fl [2];
    logic [5:0] pend;
    logic [80:0] expv, actv;
    logic [4:0] codes [4];
    logic [4:0] first;
    logic run, take_req, take_eret;
    reset = 1'b1;
    idle_inputs();
    next_cycle();
    reset = 1'b0;
    left[0] = 0; left[1] = 0; fl[0] = 1; fl[1] = 5;
    pend = 6'd0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      m_valid = ($urandom_range(3) != 0);
      pc_m    = $urandom & 32'hffff_fffc;
      bd_m    = $urandom_range(1);
      exc_f   = ($urandom_range(4) == 0) ? 5'($urandom_range(31, 1)) : 5'd0;
      exc_d   = ($urandom_range(4) == 0) ? 5'($urandom_range(31, 1)) : 5'd0;
      exc_e   = ($urandom_range(4) == 0) ? 5'($urandom_range(31, 1)) : 5'd0;
      exc_m   = ($urandom_range(4) == 0) ? 5'($urandom_range(31, 1)) : 5'd0;
      eret_m  = ($urandom_range(9) == 0);
      cp0_req = ($urandom_range(11) == 0);
      dev_int = 6'($urandom & $urandom & $urandom);
      int_ack = 6'($urandom & $urandom);
      cp0_epc = $urandom;
      @(negedge clk);
      codes = '{exc_f, exc_d, exc_e, exc_m};
      first = 5'd0;
      for (int i = 0; i < 4; i++) if (first == 5'd0) first = codes[i];
      for (int k = 0; k < 2; k++) begin
        run       = (left[k] == 0);
        take_req  = run && cp0_req;
        take_eret = run && !cp0_req && eret_m && m_valid;
        expv = {(run && m_valid) ? first : 5'd0,
                run & m_valid & bd_m,
                run ? pend : 6'd0,
                take_eret,
                !run || take_req || take_eret,
                take_req ? 2'b01 : (take_eret ? 2'b10 : 2'b00),
                take_req ? 32'h0000_4180 : (take_eret ? cp0_epc : 32'd0),
                !run,
                pc_m};
        actv = (k == 0) ? {exc_code_1, bd_1, hw_int_1, exl_clr_1, flush_1, sel_1, tgt_1, busy_1, vpc_1}
                        : {exc_code_5, bd_5, hw_int_5, exl_clr_5, flush_5, sel_5, tgt_5, busy_5, vpc_5};
        total++;
        if (actv !== expv) begin
          bad++; $display("FAIL random_dut%0d cyc=%0d: got %h want %h", fl[k], cyc, actv, expv);
        end
        if (take_req || take_eret) left[k] = fl[k];
        else if (!run) left[k] = left[k] - 1;
      end
      pend = (pend | dev_int) & ~int_ack;
      next_cycle();
    end
    idle_cycles(2);
  endtask

  initial begin
    test_reset();
    test_exc_entry();
    test_bubble();
    test_int_latch();
    test_eret();
    test_eret_vs_req();
    test_reset_mid_enter();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
